// File: rtl/tff_pkg.sv
// Shared constants for the toggle-cell counter bank.
// Mode encodings and the default bank width.
package tff_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  localparam int TFF_WIDTH = 8;

endpackage

// File: rtl/tff_counter_bank_if.sv
// Control/status bundle of the counter bank.
// master drives mode, load and data; slave returns state and flags.
interface tff_counter_bank_if #(
  parameter int WIDTH = tff_pkg::TFF_WIDTH
);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic             wrap;

  modport master (
    output en,
    output mode,
    output t,
    output load,
    output d,
    input  q,
    input  qb,
    input  tc,
    input  wrap
  );

  modport slave (
    input  en,
    input  mode,
    input  t,
    input  load,
    input  d,
    output q,
    output qb,
    output tc,
    output wrap
  );

endinterface

// File: rtl/tff_cell.sv
// Single toggle flip-flop with parallel load.
// Load beats toggle; reset value is per-cell.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t_en,
  input  logic ld,
  input  logic d,
  output logic q,
  output logic qb
);

  logic q_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= RST_VAL;
    end else if (ld) begin
      q_r <= d;
    end else if (t_en) begin
      q_r <= ~q_r;
    end
  end

  assign q  = q_r;
  assign qb = ~q_r;

endmodule

// File: rtl/tff_counter_bank.sv
// WIDTH-bit bank of toggle cells: hold, toggle-mask, up/down count.
// Carry chain, saturation gating, terminal count and wrap pulse.
module tff_counter_bank
  import tff_pkg::*;
#(
  parameter int               WIDTH    = TFF_WIDTH,
  parameter int               SATURATE = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic               clk,
  input  logic               rst,
  tff_counter_bank_if.slave  bus
);

  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] tvec;
  logic             at_max;
  logic             at_min;
  logic             wrap_nxt;
  logic             wrap_q;

  assign at_max = &q;
  assign at_min = ~|q;

  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;

  // Each cell flips when every lower cell is at the carry/borrow value.
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
    assign up_t[gi] = &q[gi-1:0];
    assign dn_t[gi] = &(~q[gi-1:0]);
  end

  always_comb begin
    tvec     = '0;
    wrap_nxt = 1'b0;
    if (bus.en) begin
      unique case (bus.mode)
        MODE_HOLD: begin
          tvec = '0;
        end
        MODE_TOGGLE: begin
          tvec = bus.t;
        end
        MODE_UP: begin
          if (!(SAT && at_max)) begin
            tvec     = up_t;
            wrap_nxt = at_max;
          end
        end
        MODE_DOWN: begin
          if (!(SAT && at_min)) begin
            tvec     = dn_t;
            wrap_nxt = at_min;
          end
        end
        default: begin
          tvec = '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell #(
      .RST_VAL (RST_VAL[gi])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .t_en (tvec[gi]),
      .ld   (bus.load),
      .d    (bus.d[gi]),
      .q    (q[gi]),
      .qb   (qb[gi])
    );
  end

  // A load cycle never reports a wrap, whatever mode/en say.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.q    = q;
  assign bus.qb   = qb;
  assign bus.wrap = wrap_q;
  assign bus.tc   = ((bus.mode == MODE_UP) && at_max) ||
                    ((bus.mode == MODE_DOWN) && at_min);

endmodule

// File: tb/tb_tff_counter_bank.sv
// Bench for tff_counter_bank: table vectors, corner sequences, random.
// Three instances (wrap, saturate, WIDTH=1) checked against a model.
module tb_tff_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [1:0] mode;
  logic [7:0] t;
  logic [7:0] d;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [7:0] R0 = 8'h00;
  localparam logic [7:0] R1 = 8'h3C;
  localparam logic [7:0] R2 = 8'h01;

  logic [7:0] mq0, mq1, mq2;
  logic       mw0, mw1, mw2;

  tff_counter_bank_if #(.WIDTH(8)) if0 ();
  tff_counter_bank_if #(.WIDTH(8)) if1 ();
  tff_counter_bank_if #(.WIDTH(1)) if2 ();

  assign if0.en = en;
  assign if0.mode = mode;
  assign if0.t = t;
  assign if0.load = load;
  assign if0.d = d;
  assign if1.en = en;
  assign if1.mode = mode;
  assign if1.t = t;
  assign if1.load = load;
  assign if1.d = d;
  assign if2.en = en;
  assign if2.mode = mode;
  assign if2.t = t[0:0];
  assign if2.load = load;
  assign if2.d = d[0:0];

  tff_counter_bank #(
    .WIDTH(8), .SATURATE(0), .RST_VAL(R0)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0));

  tff_counter_bank #(
    .WIDTH(8), .SATURATE(1), .RST_VAL(R1)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1));

  tff_counter_bank #(
    .WIDTH(1), .SATURATE(0), .RST_VAL(R2[0:0])
  ) dut2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic [7:0] d;
    logic [7:0] eq;
    logic       ew;
    logic       etc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] maxv(input int w);
    return 8'((1 << w) - 1);
  endfunction

  function automatic logic tcx(input logic [7:0] q, input int w);
    return (mode == 2'b10 && q == maxv(w)) || (mode == 2'b11 && q == 8'h00);
  endfunction

  // Counter semantics in plain arithmetic on the integer value.
  function automatic void nxt(input logic [7:0] q, input int w,
                              input bit sat, output logic [7:0] nq,
                              output logic nw);
    logic [7:0] mx;
    mx = maxv(w);
    nq = q;
    nw = 1'b0;
    if (load) begin
      nq = d & mx;
    end else if (en) begin
      case (mode)
        2'b01: nq = (q ^ t) & mx;
        2'b10: begin
          if (q == mx) begin
            if (!sat) begin
              nq = 8'h00;
              nw = 1'b1;
            end
          end else begin
            nq = q + 8'd1;
          end
        end
        2'b11: begin
          if (q == 8'h00) begin
            if (!sat) begin
              nq = mx;
              nw = 1'b1;
            end
          end else begin
            nq = q - 8'd1;
          end
        end
        default: nq = q;
      endcase
    end
  endfunction

  task automatic model_reset();
    mq0 = R0;
    mq1 = R1;
    mq2 = R2;
    mw0 = 1'b0;
    mw1 = 1'b0;
    mw2 = 1'b0;
  endtask

  task automatic check_all();
    chk("q0", if0.q, mq0);
    chk("qb0", if0.qb, ~mq0);
    chk("tc0", {7'd0, if0.tc}, {7'd0, tcx(mq0, 8)});
    chk("wrap0", {7'd0, if0.wrap}, {7'd0, mw0});
    chk("q1", if1.q, mq1);
    chk("qb1", if1.qb, ~mq1);
    chk("tc1", {7'd0, if1.tc}, {7'd0, tcx(mq1, 8)});
    chk("wrap1", {7'd0, if1.wrap}, {7'd0, mw1});
    chk("q2", {7'd0, if2.q}, mq2);
    chk("qb2", {7'd0, if2.qb}, {7'd0, ~mq2[0]});
    chk("tc2", {7'd0, if2.tc}, {7'd0, tcx(mq2, 1)});
    chk("wrap2", {7'd0, if2.wrap}, {7'd0, mw2});
  endtask

  task automatic step();
    nxt(mq0, 8, 1'b0, mq0, mw0);
    nxt(mq1, 8, 1'b1, mq1, mw1);
    nxt(mq2, 1, 1'b0, mq2, mw2);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic l, input logic e, input logic [1:0] m,
                       input logic [7:0] tv, input logic [7:0] dv);
    load = l;
    en = e;
    mode = m;
    t = tv;
    d = dv;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    model_reset();
    #12;
    check_all();
    chk("rst_q0", if0.q, 8'h00);
    chk("rst_qb0", if0.qb, 8'hFF);
    chk("rst_q1", if1.q, 8'h3C);
    @(posedge clk);
    #1;
    rst = 1'b0;

    tbl.push_back('{1'b1, 1'b0, 2'b10, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 8'h00, 8'h0F, 8'h0F, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 8'hFF, 8'h00, 8'hF0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 8'h00, 8'h00, 8'hF0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 2'b01, 8'hFF, 8'h3C, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'hA6, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 2'b10, 8'h00, 8'h10, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 2'b11, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].en, tbl[i].mode, tbl[i].t, tbl[i].d);
      step();
      chk($sformatf("tbl%0d_q", i), if0.q, tbl[i].eq);
      chk($sformatf("tbl%0d_wrap", i), {7'd0, if0.wrap}, {7'd0, tbl[i].ew});
      chk($sformatf("tbl%0d_tc", i), {7'd0, if0.tc}, {7'd0, tbl[i].etc});
    end

    // Saturating down-count from 02 stops at zero.
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h02);
    step();
    drive(1'b0, 1'b1, 2'b11, 8'h00, 8'h00);
    step();
    chk("sat_dn_q01", if1.q, 8'h01);
    step();
    chk("sat_dn_q00", if1.q, 8'h00);
    chk("sat_dn_tc", {7'd0, if1.tc}, 8'h01);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("sat_dn_hold", if1.q, 8'h00);
      chk("sat_dn_wrap", {7'd0, if1.wrap}, 8'h00);
      chk("sat_dn_tc2", {7'd0, if1.tc}, 8'h01);
    end
    drive(1'b1, 1'b0, 2'b10, 8'h00, 8'hFE);
    step();
    drive(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);
    step();
    step();
    chk("sat_up_hold", if1.q, 8'hFF);
    chk("sat_up_wrap", {7'd0, if1.wrap}, 8'h00);

    // One-bit bank: back-to-back wraps via up then down.
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h01);
    step();
    drive(1'b0, 1'b1, 2'b10, 8'h00, 8'h00);
    step();
    chk("w1_up_q", {7'd0, if2.q}, 8'h00);
    chk("w1_up_wrap", {7'd0, if2.wrap}, 8'h01);
    mode = 2'b11;
    step();
    chk("w1_dn_q", {7'd0, if2.q}, 8'h01);
    chk("w1_dn_wrap", {7'd0, if2.wrap}, 8'h01);

    // Asynchronous reset between edges while counting.
    drive(1'b1, 1'b1, 2'b10, 8'h00, 8'h5A);
    step();
    load = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #2;
    chk("arst_q0", if0.q, 8'h00);
    chk("arst_qb0", if0.qb, 8'hFF);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step();
    chk("arst_first", if0.q, 8'h01);

    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom);
      t = 8'($urandom);
      case ($urandom_range(0, 5))
        0: d = 8'hFF;
        1: d = 8'h00;
        2: d = 8'hFE;
        3: d = 8'h01;
        default: d = 8'($urandom);
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_counter_bank.md
Name: tff_counter_bank

Overview:
- Parametrised successor to the single toggle flip-flop: a WIDTH-bit bank of toggle cells sharing one clock and reset.
- Per-cycle mode selects hold, independent per-bit toggle, synchronous up-count or synchronous down-count (T-chain carry logic).
- Adds parallel load, wrap/saturate handling and a terminal-count flag.
- Used as a general event counter / toggle register in timer and divider logic.

Parameters:
- WIDTH, 8, number of toggle cells (≥1).
- SATURATE, 0: 0 means counts wrap modulo 2^WIDTH; 1 means counts stop at the boundary.
- RST_VAL, 0, value of q after reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  cycle enable for mode operations. Load ignores en.
- mode  input  2  00 hold, 01 toggle-mask, 10 count up, 11 count down.
- t  input  WIDTH  per-bit toggle request, used in mode 01 only.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load data.
- q  output  WIDTH  registered state.
- qb  output  WIDTH  always ~q, including during and after reset.
- tc  output  1  combinational terminal count: q==all-ones in mode 10, q==0 in mode 11, else 0.
- wrap  output  1  registered one-cycle pulse, set in the cycle after a count wrapped.

Behaviour:
- Reset (async, any time, including mid-count):
  - q=RST_VAL, qb=~RST_VAL, wrap=0, immediately and held while rst=1.
  - First update occurs on the first rising clk edge with rst=0.
- Priority per edge: rst > load > en. Operations complete in one cycle; q is valid after the edge.
- load=1:
  - q<=d and wrap<=0, regardless of en and mode.
  - No toggle is applied in the same cycle.
- en=0 and load=0: q holds, wrap<=0.
- Mode 00: q holds, wrap<=0.
- Mode 01: each bit toggles independently, q[i]<=q[i]^t[i]. wrap<=0.
- Mode 10 (up count):
  - Toggle vector T[0]=1, T[i]=&q[i-1:0]; q<=q^T.
  - At all-ones with SATURATE=0: q<=0, wrap<=1.
  - At all-ones with SATURATE=1: q holds, wrap<=0.
- Mode 11 (down count):
  - Toggle vector T[0]=1, T[i]=&(~q[i-1:0]).
  - At zero with SATURATE=0: q<=all-ones, wrap<=1.
  - At zero with SATURATE=1: q holds, wrap<=0.
- Mode may change on any cycle; the new mode takes effect on the next edge with no pipeline state.
- wrap is high for exactly one cycle per wrap event. Consecutive wraps (e.g. WIDTH=1 counting continuously) give wrap high on consecutive cycles.
- tc is purely combinational from q and mode. It is meaningful regardless of en.
- WIDTH=1: up and down counting both reduce to a plain toggle; tc and wrap follow the rules above.
- No X propagation: q and qb never leave the reset value until the first post-reset edge.

Decomposition:
- Shared package tff_pkg:
  - Mode constants MODE_HOLD=2'b00, MODE_TOGGLE=2'b01, MODE_UP=2'b10, MODE_DOWN=2'b11.
  - Default WIDTH constant.
- Sub-module tff_cell:
  - Single toggle cell: clk, async active-high rst, per-cell reset value, t_en, ld, d.
  - Outputs q and qb.
  - Instantiated WIDTH times by generate.
- Top level holds the T-vector/carry logic, saturation gating, tc and the wrap register.

Test Plan:
- Assert rst mid-count (q=8'h5A, mode 10) between edges → q=8'h00 and qb=8'hFF immediately, without waiting for clk. After release, the first edge gives q=8'h01.
- WIDTH=8, SATURATE=0, mode 10, en=1 from 8'hFE → q=FF with tc=1, then q=00, then wrap=1 for exactly one cycle.
- SATURATE=1, mode 11 from 8'h02 → q=01, then 00, then holds at 00 with tc=1 and wrap stays 0.
- Mode 01, q=8'h0F, t=8'hFF → q=8'hF0, qb=8'h0F. Then t=8'h00 → q holds at 8'hF0.
- load=1, d=8'hA5 with en=0 and mode 10 → q=8'hA5. Next cycle load=0, en=1 → q=8'hA6.
- en=0 for 3 cycles in mode 10 at q=8'h10 → q stays 8'h10 and wrap stays 0. Switching mode 10→11 between edges gives q=10→11→10 across the two edges.
